// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

   // Read-side behaviour: registered read or first-word-fall-through.
   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   // Width needed to hold an occupancy count of 0..depth.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Width of a pointer addressing 0..depth-1.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   // Advance a pointer by one, wrapping explicitly from depth-1 back to 0
   // so non-power-of-two depths wrap correctly.
   function automatic int unsigned ptr_inc(input int unsigned ptr,
                                           input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned PTR_W      = ptr_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  i_wr_en,
   input  logic [PTR_W-1:0]      i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [PTR_W-1:0]      i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Storage write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Asynchronous read of the addressed entry.
   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_v2.sv
// Parametrised synchronous FIFO with optional first-word-fall-through,
// runtime almost-full/empty thresholds, flush and sticky error flags.
module sync_fifo_v2
   import fifo_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = 8,
   parameter  int unsigned DEPTH      = 16,
   parameter  int unsigned FWFT       = 0,
   localparam int unsigned CNT_W      = cnt_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_flush,
   input  logic                  i_wr_en,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_rd_valid,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_almost_full,
   output logic                  o_almost_empty,
   output logic [CNT_W-1:0]      o_level,
   input  logic [CNT_W-1:0]      i_af_thresh,
   input  logic [CNT_W-1:0]      i_ae_thresh,
   output logic                  o_overflow,
   output logic                  o_underflow,
   input  logic                  i_clr_err
);

   localparam int unsigned PTR_W = ptr_width(DEPTH);
   localparam fifo_mode_e  MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_level;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_overflow;
   logic                  r_underflow;

   logic [PTR_W-1:0]      w_wr_ptr_nxt;
   logic [PTR_W-1:0]      w_rd_ptr_nxt;
   logic [CNT_W-1:0]      w_level_nxt;
   logic                  w_full_nxt;
   logic                  w_empty_nxt;
   logic                  w_overflow_nxt;
   logic                  w_underflow_nxt;

   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_ovf_set;
   logic                  w_unf_set;
   logic [DATA_WIDTH-1:0] w_mem_rd_data;

   // Acceptance decisions are made from the registered flags only.
   assign w_wr_acc  = i_wr_en && !r_full  && !i_flush;
   assign w_rd_acc  = i_rd_en && !r_empty && !i_flush;
   assign w_ovf_set = i_wr_en &&  r_full  && !i_flush;
   assign w_unf_set = i_rd_en &&  r_empty && !i_flush;

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .PTR_W      (PTR_W)
   ) u_mem (
      .clk        (clk),
      .i_wr_en    (w_wr_acc),
      .i_wr_addr  (r_wr_ptr),
      .i_wr_data  (i_wr_data),
      .i_rd_addr  (r_rd_ptr),
      .o_rd_data  (w_mem_rd_data)
   );

   // Next-state for pointers, occupancy, status and error flags.
   always_comb begin
      w_wr_ptr_nxt    = r_wr_ptr;
      w_rd_ptr_nxt    = r_rd_ptr;
      w_level_nxt     = r_level;
      w_overflow_nxt  = r_overflow;
      w_underflow_nxt = r_underflow;

      // Clear first so a coincident set takes priority.
      if (i_clr_err) begin
         w_overflow_nxt  = 1'b0;
         w_underflow_nxt = 1'b0;
      end
      if (w_ovf_set) begin
         w_overflow_nxt = 1'b1;
      end
      if (w_unf_set) begin
         w_underflow_nxt = 1'b1;
      end

      if (i_flush) begin
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
         w_level_nxt  = '0;
      end else begin
         if (w_wr_acc) begin
            w_wr_ptr_nxt = PTR_W'(ptr_inc(32'(r_wr_ptr), DEPTH));
         end
         if (w_rd_acc) begin
            w_rd_ptr_nxt = PTR_W'(ptr_inc(32'(r_rd_ptr), DEPTH));
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_nxt = r_level + CNT_W'(1);
            2'b01:   w_level_nxt = r_level - CNT_W'(1);
            default: w_level_nxt = r_level;
         endcase
      end

      w_full_nxt  = (w_level_nxt == CNT_W'(DEPTH));
      w_empty_nxt = (w_level_nxt == '0);
   end

   // State register for pointers, occupancy, status and error flags.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_level     <= w_level_nxt;
         r_full      <= w_full_nxt;
         r_empty     <= w_empty_nxt;
         r_overflow  <= w_overflow_nxt;
         r_underflow <= w_underflow_nxt;
      end
   end

   generate
      if (MODE == FIFO_FWFT) begin : g_fwft
         // Head entry is presented directly; valid whenever not empty.
         assign o_rd_data  = w_mem_rd_data;
         assign o_rd_valid = !r_empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] r_rd_data;
         logic                  r_rd_valid;

         // Registered read: capture head on an accepted read, pulse valid.
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               r_rd_data  <= '0;
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_valid <= w_rd_acc;
               if (w_rd_acc) begin
                  r_rd_data <= w_mem_rd_data;
               end
            end
         end

         assign o_rd_data  = r_rd_data;
         assign o_rd_valid = r_rd_valid;
      end
   endgenerate

   // Status outputs; almost flags follow thresholds combinationally.
   assign o_level        = r_level;
   assign o_full         = r_full;
   assign o_empty        = r_empty;
   assign o_overflow     = r_overflow;
   assign o_underflow    = r_underflow;
   assign o_almost_full  = (r_level >= i_af_thresh);
   assign o_almost_empty = (r_level <= i_ae_thresh);

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench for sync_fifo_v2: a standard-mode and an FWFT-mode instance share
// stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_v2;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 5;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          flush = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_en = 1'b0;
   logic          clr_err = 1'b0;
   logic [CW-1:0] af_thresh = CW'(3);
   logic [CW-1:0] ae_thresh = CW'(1);

   logic [DW-1:0] s_rd_data, f_rd_data;
   logic          s_rd_valid, f_rd_valid;
   logic          s_full, f_full, s_empty, f_empty;
   logic          s_af, f_af, s_ae, f_ae;
   logic [CW-1:0] s_level, f_level;
   logic          s_ovf, f_ovf, s_unf, f_unf;

   // Reference state.
   logic [DW-1:0] m_q[$];
   logic          m_ovf, m_unf, m_rv;
   logic [DW-1:0] m_rd_data;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sync_fifo_v2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_dut_std (
      .clk(clk), .reset_n(reset_n), .i_flush(flush), .i_wr_en(wr_en),
      .i_wr_data(wr_data), .i_rd_en(rd_en), .o_rd_data(s_rd_data),
      .o_rd_valid(s_rd_valid), .o_full(s_full), .o_empty(s_empty),
      .o_almost_full(s_af), .o_almost_empty(s_ae), .o_level(s_level),
      .i_af_thresh(af_thresh), .i_ae_thresh(ae_thresh),
      .o_overflow(s_ovf), .o_underflow(s_unf), .i_clr_err(clr_err)
   );

   sync_fifo_v2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_dut_fwft (
      .clk(clk), .reset_n(reset_n), .i_flush(flush), .i_wr_en(wr_en),
      .i_wr_data(wr_data), .i_rd_en(rd_en), .o_rd_data(f_rd_data),
      .o_rd_valid(f_rd_valid), .o_full(f_full), .o_empty(f_empty),
      .o_almost_full(f_af), .o_almost_empty(f_ae), .o_level(f_level),
      .i_af_thresh(af_thresh), .i_ae_thresh(ae_thresh),
      .o_overflow(f_ovf), .o_underflow(f_unf), .i_clr_err(clr_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Almost flags only, so they can be checked between edges.
   task automatic check_almost();
      int lvl = m_q.size();
      chk("s_almost_full",  32'(s_af), 32'(lvl >= int'(af_thresh)));
      chk("s_almost_empty", 32'(s_ae), 32'(lvl <= int'(ae_thresh)));
      chk("f_almost_full",  32'(f_af), 32'(lvl >= int'(af_thresh)));
      chk("f_almost_empty", 32'(f_ae), 32'(lvl <= int'(ae_thresh)));
   endtask

   task automatic check_all();
      int lvl = m_q.size();
      chk("s_level", 32'(s_level), 32'(lvl));
      chk("f_level", 32'(f_level), 32'(lvl));
      chk("s_full",  32'(s_full),  32'(lvl == int'(DEPTH)));
      chk("f_full",  32'(f_full),  32'(lvl == int'(DEPTH)));
      chk("s_empty", 32'(s_empty), 32'(lvl == 0));
      chk("f_empty", 32'(f_empty), 32'(lvl == 0));
      chk("s_overflow",  32'(s_ovf), 32'(m_ovf));
      chk("f_overflow",  32'(f_ovf), 32'(m_ovf));
      chk("s_underflow", 32'(s_unf), 32'(m_unf));
      chk("f_underflow", 32'(f_unf), 32'(m_unf));
      chk("s_rd_valid", 32'(s_rd_valid), 32'(m_rv));
      chk("s_rd_data",  32'(s_rd_data),  32'(m_rd_data));
      chk("f_rd_valid", 32'(f_rd_valid), 32'(lvl != 0));
      if (lvl != 0) begin
         chk("f_rd_data", 32'(f_rd_data), 32'(m_q[0]));
      end
      check_almost();
   endtask

   // Apply one cycle of inputs, advance the model, then check outputs.
   task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d,
                       input logic fl, input logic clr, input logic rst_n);
      logic full_now, empty_now, wa, ra;
      wr_en   = wr;
      rd_en   = rd;
      wr_data = d;
      flush   = fl;
      clr_err = clr;
      reset_n = rst_n;
      @(posedge clk);
      full_now  = (m_q.size() == int'(DEPTH));
      empty_now = (m_q.size() == 0);
      if (!rst_n) begin
         m_q.delete();
         m_ovf     = 1'b0;
         m_unf     = 1'b0;
         m_rv      = 1'b0;
         m_rd_data = '0;
      end else begin
         wa = wr && !full_now && !fl;
         ra = rd && !empty_now && !fl;
         if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
         if (wr && full_now && !fl) m_ovf = 1'b1;
         if (rd && empty_now && !fl) m_unf = 1'b1;
         m_rv = ra;
         if (fl) begin
            m_q.delete();
         end else begin
            if (ra) m_rd_data = m_q.pop_front();
            if (wa) m_q.push_back(d);
         end
      end
      #1;
      check_all();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      m_ovf = 1'b0; m_unf = 1'b0; m_rv = 1'b0; m_rd_data = '0;

      // Reset state.
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      idle();

      // Fill to full, then one more write overflows.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'h11 + i), 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      idle();
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

      // Pointer wrap past DEPTH-1.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(8'h20 + i), 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'h30 + i), 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

      // Fall-through of a single word, then pop.
      step(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      idle();
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

      // Simultaneous requests at full and at empty.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'h40 + i), 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 8'h4F, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 8'h50, 1'b0, 1'b0, 1'b1);
      // Sustained streaming keeps level constant.
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, DW'(8'h60 + i), 1'b0, 1'b0, 1'b1);
      // Set and clear in the same cycle: set wins.
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

      // Threshold moves take effect without a clock edge.
      af_thresh = CW'(3);
      ae_thresh = CW'(1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(8'h70 + i), 1'b0, 1'b0, 1'b1);
      af_thresh = CW'(4);
      #1;
      check_almost();
      step(1'b1, 1'b0, 8'h73, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

      // Flush at level 3 with a write: nothing stored, error flag kept.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(8'h80 + i), 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 8'h83, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 8'h84, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 8'h85, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 8'h86, 1'b1, 1'b0, 1'b1);
      idle();
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

      // Reset mid-stream overrides everything.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(8'h90 + i), 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic rw, rr, rf, rc, rrst;
         if ($urandom_range(0, 63) == 0) begin
            af_thresh = CW'($urandom_range(0, 7));
            ae_thresh = CW'($urandom_range(0, 7));
         end
         rw   = ($urandom_range(0, 99) < 55);
         rr   = ($urandom_range(0, 99) < 50);
         rf   = ($urandom_range(0, 99) < 2);
         rc   = ($urandom_range(0, 99) < 5);
         rrst = !($urandom_range(0, 499) == 0);
         step(rw, rr, DW'($urandom), rf, rc, rrst);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
